aes_core_scheduler: RTL and testbench

//  Shares one AES core (start/done, encrypt or decrypt) between N_REQ requesters.

---
 rtl/aes_core_scheduler.sv | 149 ++++++++++++++
 tb/tb_aes_core_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler: round-robin sharing of one AES core with tagged responses and a FIPS-197 self-test
module aes_core_scheduler #(
    parameter int N_REQ = 2,
    parameter int TIMEOUT = 64,
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_mode,
    input  logic [N_REQ*128-1:0] req_data,
    input  logic [N_REQ*128-1:0] req_key,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [127:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic                 core_mode,
    output logic [127:0]         core_din,
    output logic [127:0]         core_key,
    input  logic                 core_done,
    input  logic [127:0]         core_dout,
    input  logic                 kat_start,
    output logic                 kat_busy,
    output logic                 kat_pass,
    output logic                 kat_fail
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, KAT_E, KAT_EW, KAT_D, KAT_DW} state_t;
    state_t state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] off;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW:0] sum;
    logic [2*N_REQ-1:0] dbl;
    logic gnt_ok;
    logic [TW-1:0] timer;
    logic timer_hit;
    // rotate the valids so the first set bit is the offset from rr_ptr, then map back to an index
    always_comb begin
        dbl = {req_valid, req_valid} >> rr_ptr;
        gnt_ok = |req_valid;
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) off = dbl[i] ? IDW'(i) : off;
        sum = {1'b0, rr_ptr} + {1'b0, off};
        gnt_id = IDW'((sum >= (IDW+1)'(N_REQ)) ? sum - (IDW+1)'(N_REQ) : sum);
        nxt_ptr = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        timer_hit = timer == TW'(TIMEOUT - 1);
        req_ready = (state == IDLE && !kat_start && gnt_ok) ? N_REQ'(1) << gnt_id : '0;
    end
    // scheduler FSM: arbitration, job issue, timeout, response hand-off and self-test sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            timer <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_id <= '0;
            rsp_err <= 1'b0;
            core_start <= 1'b0;
            core_mode <= 1'b0;
            core_din <= '0;
            core_key <= '0;
            kat_busy <= 1'b0;
            kat_pass <= 1'b0;
            kat_fail <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (kat_start) begin
                        kat_pass <= 1'b0;
                        kat_fail <= 1'b0;
                        kat_busy <= 1'b1;
                        core_start <= 1'b1;
                        core_mode <= 1'b0;
                        core_din <= KAT_PT;
                        core_key <= KAT_KEY;
                        state <= KAT_E;
                    end else if (gnt_ok) begin
                        core_start <= 1'b1;
                        core_mode <= req_mode[gnt_id];
                        core_din <= req_data[128*gnt_id +: 128];
                        core_key <= req_key[128*gnt_id +: 128];
                        rsp_id <= gnt_id;
                        rr_ptr <= nxt_ptr;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done || timer_hit) begin
                        rsp_data <= core_done ? core_dout : '0;
                        rsp_err <= !core_done;
                        rsp_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                KAT_E, KAT_D: begin
                    timer <= '0;
                    state <= (state == KAT_E) ? KAT_EW : KAT_DW;
                end
                KAT_EW: begin
                    if (core_done && core_dout == KAT_CT) begin
                        core_din <= core_dout;
                        core_mode <= 1'b1;
                        core_start <= 1'b1;
                        state <= KAT_D;
                    end else if (core_done || timer_hit) begin
                        kat_fail <= 1'b1;
                        kat_busy <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                KAT_DW: begin
                    if (core_done || timer_hit) begin
                        kat_pass <= core_done && core_dout == KAT_PT;
                        kat_fail <= !(core_done && core_dout == KAT_PT);
                        kat_busy <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core_scheduler.sv
// tb_aes_core_scheduler: directed and randomized checks of the shared AES core scheduler
module tb_aes_core_scheduler;
    localparam int N = 2;
    localparam int TO = 64;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_mode = '0;
    logic [N*128-1:0] req_data = '0;
    logic [N*128-1:0] req_key = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [127:0] rsp_data;
    logic [0:0] rsp_id;
    logic rsp_err;
    logic core_start, core_mode;
    logic [127:0] core_din, core_key;
    logic core_done = 1'b0;
    logic [127:0] core_dout = '0;
    logic kat_start = 1'b0;
    logic kat_busy, kat_pass, kat_fail;
    int n_chk = 0;
    int n_pass = 0;
    int ref_ptr = 0;
    int lat_cfg = 3;
    logic never_done = 1'b0;
    logic corrupt = 1'b0;
    logic pend = 1'b0;
    int cnt = 0;
    logic [127:0] res = '0;
    logic [127:0] exp_q[$];
    int id_q[$];

    aes_core_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_data(req_data), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .core_start(core_start),
        .core_mode(core_mode), .core_din(core_din), .core_key(core_key), .core_done(core_done),
        .core_dout(core_dout), .kat_start(kat_start), .kat_busy(kat_busy), .kat_pass(kat_pass),
        .kat_fail(kat_fail)
    );

    always #5 clk = ~clk;

    // stand-in cipher: exact FIPS-197 pair for the known answer, a reversible mix otherwise
    function automatic logic [127:0] aes_fn(logic m, logic [127:0] d, logic [127:0] k);
        if (!m && d == PT && k == KEY) return CT;
        if (m && d == CT && k == KEY) return PT;
        return {d[63:0], d[127:64]} ^ k ^ {128{m}};
    endfunction

    // core model: result lat_cfg+1 cycles after start; ignores the scheduler reset so stale results can arrive
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start && !never_done) begin
            pend <= 1'b1;
            cnt <= lat_cfg;
            res <= aes_fn(core_mode, core_din, core_key) ^ {127'b0, corrupt};
        end else if (pend) begin
            if (cnt <= 1) begin
                core_done <= 1'b1;
                core_dout <= res;
                pend <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_rsp(int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        chk("rsp_arrive", 512'(rsp_valid), 512'(1));
    endtask

    task automatic new_job(int i);
        req_mode[i] = 1'($urandom_range(0, 1));
        req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_key[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic [127:0] exp_of(int i);
        return aes_fn(req_mode[i], req_data[i*128 +: 128], req_key[i*128 +: 128]);
    endfunction

    function automatic int ref_grant();
        for (int k = 0; k < N; k++) if (req_valid[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [511:0] all_outs();
        return 512'({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, core_start, core_mode,
                     core_din, core_key, kat_busy, kat_pass, kat_fail});
    endfunction

    task automatic run_random(int njobs, int pv);
        int grants = 0;
        int budget = 0;
        int last = -1;
        int alt_bad = 0;
        int g;
        int id;
        logic [127:0] e;
        logic [N-1:0] regen = '0;
        while ((grants < njobs || req_valid != '0 || exp_q.size() != 0 || rsp_valid) && budget < 5000) begin
            for (int i = 0; i < N; i++) if (regen[i]) req_valid[i] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && grants < njobs && int'($urandom_range(0, 99)) < pv) begin
                    new_job(i);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = (pv >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            lat_cfg = int'($urandom_range(1, 8));
            #1;
            regen = req_ready & req_valid;
            if (req_ready != '0) begin
                g = ref_grant();
                chk("rr_grant", 512'(req_ready), (g < 0) ? 512'(0) : (512'(1) << g));
                if (g >= 0) begin
                    exp_q.push_back(exp_of(g));
                    id_q.push_back(g);
                    ref_ptr = (g + 1) % N;
                    grants++;
                    if (g == last) alt_bad++;
                    last = g;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $error("FAIL rsp_unexpected observed=response id %0d expected=no response", rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    id = id_q.pop_front();
                    chk("rand_rsp", 512'({rsp_err, rsp_id, rsp_data}), 512'({1'b0, 1'(id), e}));
                end
            end
            tick();
            budget++;
        end
        chk("rand_drain", 512'({req_valid, 32'(exp_q.size()), rsp_valid}), 512'(0));
        if (pv >= 100) chk("rr_alternate", 512'(alt_bad), 512'(0));
        rsp_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=no finish expected=finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] e0, e1;
        int n;
        int bad;
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 512'(0));
        rst = 1'b0;
        tick();
        // single FIPS encrypt from requester 0
        req_mode[0] = 1'b0;
        req_data[127:0] = PT;
        req_key[127:0] = KEY;
        req_valid = 2'b01;
        #1 chk("t1_grant", 512'(req_ready), 512'(2'b01));
        tick();
        chk("t1_issue", 512'({core_start, core_mode, core_din, core_key}), 512'({1'b1, 1'b0, PT, KEY}));
        req_valid = '0;
        wait_rsp(40);
        chk("t1_rsp", 512'({rsp_err, rsp_id, rsp_data}), 512'({1'b0, 1'b0, CT}));
        tick();
        chk("t1_rsp_done", 512'(rsp_valid), 512'(0));
        // back-pressure: response held, no grants while stalled
        rsp_ready = 1'b0;
        new_job(0);
        new_job(1);
        e0 = exp_of(0);
        e1 = exp_of(1);
        req_valid = 2'b11;
        #1 chk("t3_grant1", 512'(req_ready), 512'(2'b10));
        tick();
        wait_rsp(40);
        for (int c = 0; c < 20; c++) begin
            chk("t3_hold", 512'({rsp_valid, rsp_id, req_ready, rsp_data}), 512'({1'b1, 1'b1, 2'b00, e1}));
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("t3_no_grant_in_resp", 512'(req_ready), 512'(0));
        tick();
        #1 chk("t3_grant0_after_hs", 512'({rsp_valid, req_ready}), 512'({1'b0, 2'b01}));
        req_valid[1] = 1'b0;
        tick();
        req_valid = '0;
        wait_rsp(40);
        chk("t3_rsp0", 512'({rsp_err, rsp_id, rsp_data}), 512'({1'b0, 1'b0, e0}));
        tick();
        // continuous contention then mixed random traffic
        ref_ptr = 1;
        run_random(8, 100);
        run_random(30, 40);
        // timeout
        lat_cfg = 3;
        never_done = 1'b1;
        new_job(0);
        req_valid = 2'b01;
        #1 chk("t4_grant", 512'(req_ready), 512'(2'b01));
        tick();
        chk("t4_start", 512'(core_start), 512'(1));
        req_valid = '0;
        kat_start = 1'b1;
        tick();
        kat_start = 1'b0;
        #1 chk("t4_kat_ignored", 512'(kat_busy), 512'(0));
        n = 1;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        chk("t4_latency", 512'(n), 512'(TO + 1));
        chk("t4_err_rsp", 512'({rsp_valid, rsp_err, rsp_id, rsp_data}), 512'({1'b1, 1'b1, 1'b0, 128'h0}));
        tick();
        never_done = 1'b0;
        // self-test with a correct core, a request waiting meanwhile
        new_job(1);
        e1 = exp_of(1);
        req_valid = 2'b10;
        kat_start = 1'b1;
        #1 chk("t5_kat_priority", 512'(req_ready), 512'(0));
        tick();
        kat_start = 1'b0;
        #1 chk("t5_kat_e", 512'({kat_busy, core_start, core_mode, core_din, core_key}), 512'({1'b1, 1'b1, 1'b0, PT, KEY}));
        bad = 0;
        n = 0;
        while (kat_busy && n < 300) begin
            tick();
            n++;
            if (kat_busy && (req_ready != '0 || rsp_valid)) bad++;
        end
        chk("t5_quiet_during_kat", 512'(bad), 512'(0));
        chk("t5_kat_pass", 512'({kat_busy, kat_pass, kat_fail}), 512'(3'b010));
        #1 chk("t5_grant_after_kat", 512'(req_ready), 512'(2'b10));
        tick();
        req_valid = '0;
        wait_rsp(40);
        chk("t5_rsp1", 512'({rsp_err, rsp_id, rsp_data}), 512'({1'b0, 1'b1, e1}));
        tick();
        // self-test with a core that flips bit 0
        corrupt = 1'b1;
        kat_start = 1'b1;
        tick();
        kat_start = 1'b0;
        n = 0;
        while (kat_busy && n < 300) begin
            tick();
            n++;
        end
        chk("t5_kat_fail", 512'({kat_busy, kat_pass, kat_fail}), 512'(3'b001));
        corrupt = 1'b0;
        // reset while waiting on the core; the late result must be dropped
        lat_cfg = 10;
        new_job(0);
        req_valid = 2'b01;
        #1 chk("t6_grant", 512'(req_ready), 512'(2'b01));
        tick();
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_outputs_zero", all_outs(), 512'(0));
        bad = 0;
        repeat (15) begin
            tick();
            if (rsp_valid || core_start) bad++;
        end
        chk("t6_no_stale_rsp", 512'(bad), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
